// File: rtl/pgm_sched_if.sv
// Bus bundle for the packet generator: config pulses, RAM read port, output
// packet stream and status.
interface pgm_sched_if;
    logic         cfg_start;
    logic         cfg_stop;
    logic [31:0]  cfg_pkt_num;
    logic [15:0]  cfg_gap;
    logic [6:0]   cfg_last_addr;
    logic         ram_rd_en;
    logic [6:0]   ram_raddr;
    logic [143:0] ram_rdata;
    logic [133:0] out_pgm_data;
    logic         out_pgm_data_wr;
    logic         out_pgm_valid_wr;
    logic         out_pgm_valid;
    logic         in_pgm_alf;
    logic         busy;
    logic [31:0]  sent_cnt;

    modport slave (
        input  cfg_start, cfg_stop, cfg_pkt_num, cfg_gap, cfg_last_addr,
        input  ram_rdata, in_pgm_alf,
        output ram_rd_en, ram_raddr, out_pgm_data, out_pgm_data_wr,
        output out_pgm_valid_wr, out_pgm_valid, busy, sent_cnt
    );

    modport master (
        output cfg_start, cfg_stop, cfg_pkt_num, cfg_gap, cfg_last_addr,
        output ram_rdata, in_pgm_alf,
        input  ram_rd_en, ram_raddr, out_pgm_data, out_pgm_data_wr,
        input  out_pgm_valid_wr, out_pgm_valid, busy, sent_cnt
    );
endinterface

// File: rtl/pgm_sched.sv
// Packet generator: replays a RAM-resident packet a configured number of
// times with fixed idle gaps, gated at packet starts by downstream almost-full.
module pgm_sched (
    input  logic clk,
    input  logic rst,
    pgm_sched_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_GAP} state_t;

    state_t        r_state;
    logic [31:0]   r_pkt_num;
    logic [15:0]   r_gap;
    logic [6:0]    r_last;
    logic [31:0]   r_issued;
    logic          r_stop_pend;
    logic [15:0]   r_gap_cnt;
    logic [6:0]    r_addr;
    logic          r_in_pkt;
    logic          r_rd_vld;
    logic          r_rd_last;
    logic [133:0]  r_out_data;
    logic          r_out_wr;
    logic          r_out_valid;
    logic [31:0]   r_sent;

    logic          w_stop;
    logic          w_first_ok;
    logic          w_rd_en;
    logic [6:0]    w_raddr;
    logic          w_rd_last;
    logic [31:0]   w_issued_nx;
    logic          w_done;
    logic          w_unused;

    assign w_unused    = ^bus.ram_rdata[143:134];
    assign w_stop      = r_stop_pend | bus.cfg_stop;
    // A new packet may only begin when downstream has room and no stop is pending.
    assign w_first_ok  = (r_state == S_READ) && !r_in_pkt && !bus.in_pgm_alf && !w_stop;
    assign w_rd_en     = ((r_state == S_READ) && r_in_pkt) || w_first_ok;
    assign w_raddr     = (w_rd_en && r_in_pkt) ? r_addr : 7'd0;
    assign w_rd_last   = w_rd_en && (w_raddr == r_last);
    assign w_issued_nx = r_issued + 32'd1;
    assign w_done      = w_stop || ((r_pkt_num != 32'd0) && (w_issued_nx == r_pkt_num));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pkt_num   <= '0;
            r_gap       <= '0;
            r_last      <= '0;
            r_issued    <= '0;
            r_stop_pend <= 1'b0;
            r_gap_cnt   <= '0;
            r_addr      <= '0;
            r_in_pkt    <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_rd_last   <= 1'b0;
            r_out_data  <= '0;
            r_out_wr    <= 1'b0;
            r_out_valid <= 1'b0;
            r_sent      <= '0;
        end else begin
            // RAM returns data one cycle after the strobe; the output register adds the second.
            r_rd_vld    <= w_rd_en;
            r_rd_last   <= w_rd_last;
            r_out_wr    <= r_rd_vld;
            r_out_valid <= r_rd_vld & r_rd_last;
            if (r_rd_vld)
                r_out_data <= bus.ram_rdata[133:0];

            if (r_state == S_IDLE && bus.cfg_start)
                r_sent <= '0;
            else if (r_rd_vld && r_rd_last)
                r_sent <= r_sent + 32'd1;

            if (r_state != S_IDLE && bus.cfg_stop)
                r_stop_pend <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    r_stop_pend <= 1'b0;
                    if (bus.cfg_start) begin
                        r_pkt_num <= bus.cfg_pkt_num;
                        r_gap     <= bus.cfg_gap;
                        r_last    <= bus.cfg_last_addr;
                        r_issued  <= '0;
                        r_in_pkt  <= 1'b0;
                        r_addr    <= '0;
                        r_state   <= S_READ;
                    end
                end
                S_READ: begin
                    if (!r_in_pkt && w_stop) begin
                        r_stop_pend <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (w_rd_en) begin
                        if (w_rd_last) begin
                            r_issued <= w_issued_nx;
                            r_in_pkt <= 1'b0;
                            r_addr   <= '0;
                            if (w_done) begin
                                r_stop_pend <= 1'b0;
                                r_state     <= S_IDLE;
                            end else if (r_gap != 16'd0) begin
                                r_gap_cnt <= r_gap;
                                r_state   <= S_GAP;
                            end
                        end else begin
                            r_in_pkt <= 1'b1;
                            r_addr   <= w_raddr + 7'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (w_stop) begin
                        r_stop_pend <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (r_gap_cnt == 16'd1) begin
                        r_state <= S_READ;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ram_rd_en        = w_rd_en;
    assign bus.ram_raddr        = w_raddr;
    assign bus.out_pgm_data     = r_out_data;
    assign bus.out_pgm_data_wr  = r_out_wr;
    assign bus.out_pgm_valid_wr = r_out_valid;
    assign bus.out_pgm_valid    = r_out_valid;
    assign bus.busy             = (r_state != S_IDLE);
    assign bus.sent_cnt         = r_sent;
endmodule

// File: tb/tb_pgm_sched.sv
// Randomized scoreboard bench for pgm_sched: expected words queued at run
// start, a negedge monitor checks read timing, output words and counters.
module tb_pgm_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pgm_sched_if bus();
    pgm_sched dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [133:0] data;
        logic         last;
    } exp_t;

    logic [143:0] mem [128];
    exp_t exp_q[$];
    int   rd_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // reference model state for the current run
    int pkts_left = 0;
    int exp_addr = 0;
    bit waiting = 0;
    int earliest = 0;
    int cur_last = 0;
    int cur_gap = 0;
    int out_pkts = 0;
    int pkts_started = 0;
    int busy_fall_at = -1;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.ram_rd_en) bus.ram_rdata <= mem[bus.ram_raddr];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic check_d(input string nm, input logic [133:0] act, input logic [133:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        int   t;
        if (!rst) begin
            if (bus.out_pgm_data_wr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_d("out_data", bus.out_pgm_data, e.data);
                    check("valid_wr", int'(bus.out_pgm_valid_wr), int'(e.last));
                    check("valid", int'(bus.out_pgm_valid), int'(e.last));
                    if (rd_q.size() == 0) check("latency_nord", 1, 0);
                    else begin
                        t = rd_q.pop_front();
                        check("latency", cyc, t + 2);
                    end
                    if (e.last) begin
                        out_pkts++;
                        check("sent_cnt_live", int'(bus.sent_cnt), out_pkts);
                    end
                end
            end else if (bus.out_pgm_valid_wr || bus.out_pgm_valid) begin
                check("valid_without_wr", 1, 0);
            end

            if (!bus.ram_rd_en && bus.ram_raddr != 7'd0)
                check("raddr_idle", int'(bus.ram_raddr), 0);

            if (pkts_left == 0) begin
                if (bus.ram_rd_en) check("spurious_read", 1, 0);
                if (busy_fall_at == cyc) check("busy_fall", int'(bus.busy), 0);
            end else if (waiting) begin
                if (bus.ram_rd_en) begin
                    check("start_early", int'(cyc >= earliest && !bus.in_pgm_alf), 1);
                    waiting = 0;
                end else if (cyc >= earliest && !bus.in_pgm_alf) begin
                    check("start_late", 1, 0);
                end
            end else begin
                check("read_burst", int'(bus.ram_rd_en), 1);
            end

            if (pkts_left > 0 && bus.ram_rd_en) begin
                check("raddr", int'(bus.ram_raddr), exp_addr);
                check("busy_run", int'(bus.busy), 1);
                rd_q.push_back(cyc);
                if (exp_addr == 0) pkts_started++;
                if (exp_addr == cur_last) begin
                    exp_addr = 0;
                    pkts_left--;
                    waiting = (pkts_left > 0);
                    earliest = cyc + cur_gap + 1;
                    if (pkts_left == 0) busy_fall_at = cyc + 1;
                end else begin
                    exp_addr++;
                end
            end
        end
    end

    // n_model: packets the model expects (for continuous runs, where the stop lands)
    task automatic run_start(input int last, input int npkt, input int gap, input int n_model);
        bus.cfg_last_addr = 7'(last);
        bus.cfg_pkt_num   = 32'(npkt);
        bus.cfg_gap       = 16'(gap);
        cur_last = last;
        cur_gap = gap;
        pkts_left = n_model;
        exp_addr = 0;
        waiting = 1;
        earliest = cyc + 1;
        out_pkts = 0;
        pkts_started = 0;
        busy_fall_at = -1;
        for (int p = 0; p < n_model; p++)
            for (int a = 0; a <= last; a++)
                exp_q.push_back('{data: mem[a][133:0], last: (a == last)});
        bus.cfg_start = 1'b1;
        @(posedge clk); #1;
        bus.cfg_start = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);
    endtask

    task automatic wait_done(input int n, input bit rnd_alf);
        int i;
        for (i = 0; i < 3000 && (pkts_left != 0 || exp_q.size() != 0); i++) begin
            @(posedge clk); #1;
            if (rnd_alf) bus.in_pgm_alf = ($urandom_range(0, 3) == 0);
        end
        bus.in_pgm_alf = 1'b0;
        if (i >= 3000) check("run_timeout", 1, 0);
        repeat (3) @(posedge clk);
        #1;
        check("sent_cnt_end", int'(bus.sent_cnt), n);
        check("busy_end", int'(bus.busy), 0);
    endtask

    task automatic wait_rd(input int addr, input int pkt);
        bit found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (bus.ram_rd_en && int'(bus.ram_raddr) == addr && pkts_started == pkt) found = 1;
        end
        if (!found) check("wait_read_timeout", 1, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", int'(bus.busy), 0);
        check("rst_sent", int'(bus.sent_cnt), 0);
        check_d("rst_data", bus.out_pgm_data, '0);
        check("rst_data_wr", int'(bus.out_pgm_data_wr), 0);
        check("rst_valid_wr", int'(bus.out_pgm_valid_wr), 0);
        check("rst_valid", int'(bus.out_pgm_valid), 0);
        check("rst_rd_en", int'(bus.ram_rd_en), 0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++)
            mem[i] = {16'($urandom()), $urandom(), $urandom(), $urandom(), $urandom()};
        bus.cfg_start = 1'b0;
        bus.cfg_stop = 1'b0;
        bus.cfg_pkt_num = '0;
        bus.cfg_gap = '0;
        bus.cfg_last_addr = '0;
        bus.in_pgm_alf = 1'b0;
        bus.ram_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // back-to-back packets, no gap
        run_start(3, 2, 0, 2);
        wait_done(2, 0);
        // gapped packets
        run_start(1, 3, 5, 3);
        wait_done(3, 0);
        // single-word packet
        run_start(0, 1, 0, 1);
        wait_done(1, 0);

        // continuous run stopped during 4th packet's second read
        run_start(2, 0, 1, 4);
        wait_rd(1, 4);
        bus.cfg_stop = 1'b1;
        @(posedge clk); #1;
        bus.cfg_stop = 1'b0;
        wait_done(4, 0);

        // almost-full at start holds off, almost-full mid-packet is ignored
        bus.in_pgm_alf = 1'b1;
        run_start(7, 1, 0, 1);
        repeat (10) @(posedge clk);
        #1;
        bus.in_pgm_alf = 1'b0;
        wait_rd(3, 1);
        bus.in_pgm_alf = 1'b1;
        wait_done(1, 0);

        // reset mid-packet after an ignored second start
        run_start(5, 3, 0, 3);
        wait_rd(2, 1);
        @(posedge clk); #1;
        bus.cfg_start = 1'b1;
        @(posedge clk); #1;
        bus.cfg_start = 1'b0;
        rst = 1'b1;
        pkts_left = 0;
        waiting = 0;
        busy_fall_at = -1;
        exp_q.delete();
        rd_q.delete();
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_sent", int'(bus.sent_cnt), 0);
        check("post_rst_busy", int'(bus.busy), 0);

        // randomized runs with random almost-full
        for (int r = 0; r < 8; r++) begin
            int l, n, g;
            l = $urandom_range(0, 15);
            n = $urandom_range(1, 4);
            g = $urandom_range(0, 6);
            run_start(l, n, g, n);
            wait_done(n, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pgm_sched.md
PGM_SCHED -- requirements
Module: pgm_sched

Interface
REQ-001 clk  in  1  single clock; all logic rising-edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 cfg_start  in  1  one-cycle pulse; begin generation run.
REQ-004 cfg_stop  in  1  one-cycle pulse; end run at next packet boundary.
REQ-005 cfg_pkt_num  in  32  packets per run; 0 = continuous until stop.
REQ-006 cfg_gap  in  16  idle cycles between packets.
REQ-007 cfg_last_addr  in  7  RAM address of last word of stored packet (packet length = cfg_last_addr+1 words).
REQ-008 ram_rd_en  out  1  RAM read strobe.
REQ-009 ram_raddr  out  7  RAM read address.
REQ-010 ram_rdata  in  144  RAM read data, valid exactly 1 cycle after ram_rd_en.
REQ-011 out_pgm_data  out  134  generated packet word, ram_rdata[133:0].
REQ-012 out_pgm_data_wr  out  1  out_pgm_data write strobe.
REQ-013 out_pgm_valid_wr  out  1  packet-valid strobe, with last word.
REQ-014 out_pgm_valid  out  1  packet-valid flag, with out_pgm_valid_wr.
REQ-015 in_pgm_alf  in  1  downstream almost-full.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 sent_cnt  out  32  packets fully emitted in current run.

Function
REQ-018 States: IDLE, READ, GAP; config fields latched into internal registers on accepted cfg_start.
REQ-019 IDLE: cfg_start accepted -> clear sent_cnt, go READ; cfg_start ignored in READ/GAP.
REQ-020 READ entry / per-packet start: first read issued only in a cycle with in_pgm_alf=0; while alf=1 at packet start, hold with ram_rd_en=0.
REQ-021 READ: once first word issued, ram_rd_en=1 every cycle, ram_raddr 0,1,...,last_addr with no stall; alf ignored mid-packet.
REQ-022 Datapath latency: out_pgm_data/out_pgm_data_wr registered; word read at cycle t appears at t+2.
REQ-023 out_pgm_valid_wr=out_pgm_valid=1 in same cycle as last word's out_pgm_data_wr; 0 otherwise.
REQ-024 sent_cnt increments by 1 in cycle last word is output (32-bit wrap permitted in continuous mode).
REQ-025 After last-address read: if run done -> IDLE; else cfg_gap=0 -> next packet start check next cycle; else GAP.
REQ-026 GAP: counter loaded cfg_gap, counts down 1/cycle; reaching 1 -> next packet start check next cycle (exactly cfg_gap idle read cycles).
REQ-027 Run done when (pkt_num!=0 and packets issued == pkt_num) or stop pending; stop pulse in any non-IDLE state sets stop pending, packet in flight always completes.
REQ-028 cfg_stop in IDLE ignored; stop pending cleared on entry to IDLE.
REQ-029 cfg_last_addr=0: single-word packet; first word carries out_pgm_valid_wr.
REQ-030 busy deasserts when entering IDLE; last words still drain through 2-cycle pipe afterwards.
REQ-031 ram_raddr=0 whenever ram_rd_en=0.

Reset
REQ-032 rst asynchronous: state=IDLE; all outputs 0 (out_pgm_data=134'b0, sent_cnt=0, busy=0); counters and stop pending cleared.
REQ-033 rst mid-packet aborts immediately; no further data words; after release, nothing until new cfg_start.

Verification
REQ-034 last_addr=3, pkt_num=2, gap=0, alf=0, start -> reads 0..3,0..3 back-to-back; 8 data words; valid_wr on words 4 and 8; sent_cnt=2; busy falls after cycle of 2nd addr 3.
REQ-035 last_addr=1, pkt_num=3, gap=5 -> exactly 5 cycles ram_rd_en=0 between packets; sent_cnt ends 3.
REQ-036 pkt_num=0, last_addr=2, stop pulsed during 4th packet's 2nd read -> 4th packet completes, sent_cnt=4, IDLE.
REQ-037 alf=1 at start for 10 cycles then 0 -> no reads for 10 cycles; alf raised mid-packet -> packet continues uninterrupted.
REQ-038 last_addr=0, pkt_num=1 -> one word with out_pgm_data_wr and out_pgm_valid_wr same cycle, 2 cycles after read.
REQ-039 rst asserted mid-packet, second cfg_start issued while busy -> outputs 0 immediately; busy start ignored; no output after rst release until new start.
